// File: rtl/el_power_accum_if.sv
// el_power_accum_if: sample/strobe inputs and power outputs of the early/late power correlator
interface el_power_accum_if #(
    parameter int IN_W = 4
);
    logic signed [IN_W-1:0] sample_i;
    logic signed [IN_W-1:0] sample_q;
    logic                   sample_valid;
    logic                   code_e;
    logic                   code_l;
    logic                   dump;
    logic [28:0]            p_e;
    logic [28:0]            p_l;
    logic                   p_valid;
    logic                   sat;

    modport master (
        output sample_i, sample_q, sample_valid, code_e, code_l, dump,
        input  p_e, p_l, p_valid, sat
    );

    modport slave (
        input  sample_i, sample_q, sample_valid, code_e, code_l, dump,
        output p_e, p_l, p_valid, sat
    );
endinterface

// File: rtl/el_power_accum.sv
// el_power_accum: early/late integrate-and-dump with a 3-stage shift/clip, square, sum power pipeline
module el_power_accum #(
    parameter int IN_W      = 4,
    parameter int ACC_W     = 18,
    parameter int PWR_SHIFT = 4,
    parameter int SQ_W      = 14
) (
    input  logic               clk,
    input  logic               rst,
    el_power_accum_if.slave    bus
);
    localparam logic signed [ACC_W:0]   AMAX = (ACC_W+1)'(2**(ACC_W-1)-1);
    localparam logic signed [ACC_W:0]   AMIN = -AMAX;
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(2**(SQ_W-1)-1);
    localparam logic signed [ACC_W-1:0] SMIN = -SMAX;
    localparam int                      SQW  = 2*SQ_W-2;

    // Index order everywhere: 0=ie, 1=qe, 2=il, 3=ql
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic signed [ACC_W-1:0] step_v [4];
    logic signed [ACC_W-1:0] cap_q [4];
    logic signed [ACC_W-1:0] sh [4];
    logic signed [ACC_W:0]   ext [4];
    logic signed [ACC_W:0]   sum [4];
    logic signed [SQ_W-1:0]  shv_q [4];
    logic signed [SQ_W-1:0]  shv_d [4];
    logic [SQ_W-2:0]         mag [4];
    logic [SQW-1:0]          sq_q [4];
    logic [SQW-1:0]          sq_d [4];
    logic                    neg [4];
    logic                    sat_acc_q, sat_acc_d, step_sat;
    logic                    cap_v_q, cap_sat_q;
    logic                    sh_v_q, sh_sat_q, sh_sat_d;
    logic                    sq_v_q, sq_sat_q;
    logic [28:0]             p_e_q, p_l_q;
    logic                    p_valid_q, sat_q;

    always_comb begin
        step_sat = 1'b0;
        sh_sat_d = cap_sat_q;
        for (int k = 0; k < 4; k++) begin
            ext[k]    = (ACC_W+1)'(k[0] ? bus.sample_q : bus.sample_i);
            neg[k]    = k[1] ? bus.code_l : bus.code_e;
            sum[k]    = (ACC_W+1)'(acc_q[k]) + (neg[k] ? -ext[k] : ext[k]);
            step_v[k] = ACC_W'(sum[k] > AMAX ? AMAX : sum[k] < AMIN ? AMIN : sum[k]);
            step_sat  = step_sat | (bus.sample_valid & (sum[k] > AMAX | sum[k] < AMIN));
            acc_d[k]  = bus.dump ? '0 : bus.sample_valid ? step_v[k] : acc_q[k];
            sh[k]     = cap_q[k] >>> PWR_SHIFT;
            shv_d[k]  = SQ_W'(sh[k] > SMAX ? SMAX : sh[k] < SMIN ? SMIN : sh[k]);
            sh_sat_d  = sh_sat_d | sh[k] > SMAX | sh[k] < SMIN;
            mag[k]    = (SQ_W-1)'(shv_q[k] < 0 ? -shv_q[k] : shv_q[k]);
            sq_d[k]   = SQW'(mag[k]) * SQW'(mag[k]);
        end
        sat_acc_d = bus.dump ? 1'b0 : sat_acc_q | step_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= '0;
                cap_q[k] <= '0;
                shv_q[k] <= '0;
                sq_q[k]  <= '0;
            end
            sat_acc_q <= 1'b0;
            cap_v_q   <= 1'b0;
            cap_sat_q <= 1'b0;
            sh_v_q    <= 1'b0;
            sh_sat_q  <= 1'b0;
            sq_v_q    <= 1'b0;
            sq_sat_q  <= 1'b0;
            p_e_q     <= '0;
            p_l_q     <= '0;
            p_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= acc_d[k];
                cap_q[k] <= bus.dump ? (bus.sample_valid ? step_v[k] : acc_q[k]) : cap_q[k];
                shv_q[k] <= shv_d[k];
                sq_q[k]  <= sq_d[k];
            end
            sat_acc_q <= sat_acc_d;
            cap_v_q   <= bus.dump;
            cap_sat_q <= bus.dump ? sat_acc_q | step_sat : cap_sat_q;
            sh_v_q    <= cap_v_q;
            sh_sat_q  <= sh_sat_d;
            sq_v_q    <= sh_v_q;
            sq_sat_q  <= sh_sat_q;
            p_valid_q <= sq_v_q;
            if (sq_v_q) begin
                p_e_q <= 29'(sq_q[0]) + 29'(sq_q[1]);
                p_l_q <= 29'(sq_q[2]) + 29'(sq_q[3]);
                sat_q <= sq_sat_q;
            end
        end
    end

    assign bus.p_e     = p_e_q;
    assign bus.p_l     = p_l_q;
    assign bus.p_valid = p_valid_q;
    assign bus.sat     = sat_q;
endmodule
